// File: rtl/serial_tx_arbiter.sv
//------------------------------------------------------------------------------
// serial_tx_arbiter
//
// Shares one serial_tx byte transmitter among N_REQ independent byte sources.
// Ownership is granted round-robin at packet granularity: once a requester
// wins, it keeps the transmitter until a byte flagged "last" is accepted, so
// packets never interleave on the wire.
//
// Ports:
//   i_clk     system clock
//   i_rst_n   synchronous reset, active-low
//   i_req     per-requester byte valid, held until the matching o_ack
//   i_data    flattened bytes, requester k at [8k+7:8k]
//   i_last    per-requester "this byte ends the packet"
//   o_ack     one-cycle pulse: byte from requester k accepted by serial_tx
//   o_grant   one-hot current owner, zero when idle
//   o_wr      write strobe to serial_tx i_wr
//   o_data    byte to serial_tx i_data
//   i_busy    serial_tx o_busy
//
// Optional build macro: SERIAL_TX_ARB_TIMEOUT_EN
//   When defined, an owner that stalls in LOAD for TIMEOUT clocks loses its
//   grant and the round-robin pointer moves past it. When undefined, a stalled
//   owner holds the lock indefinitely.
//------------------------------------------------------------------------------
module serial_tx_arbiter #(
   parameter int N_REQ   = 4,
   parameter int TIMEOUT = 1024
) (
   input  logic                 i_clk,
   input  logic                 i_rst_n,
   input  logic [N_REQ-1:0]     i_req,
   input  logic [8*N_REQ-1:0]   i_data,
   input  logic [N_REQ-1:0]     i_last,
   output logic [N_REQ-1:0]     o_ack,
   output logic [N_REQ-1:0]     o_grant,
   output logic                 o_wr,
   output logic [7:0]           o_data,
   input  logic                 i_busy
);

   localparam int IW = $clog2(N_REQ);
   localparam logic [IW:0] N_W = (IW+1)'(N_REQ);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_LOAD = 2'd1,
      ST_SEND = 2'd2,
      ST_GAP  = 2'd3
   } state_t;

   state_t            state_q, state_d;
   logic [N_REQ-1:0]  grant_q, grant_d;
   logic [IW-1:0]     gidx_q,  gidx_d;
   logic [IW-1:0]     rr_q,    rr_d;
   logic [N_REQ-1:0]  ack_q,   ack_d;
   logic              wr_q,    wr_d;
   logic [7:0]        data_q,  data_d;
   logic              last_q,  last_d;

`ifdef SERIAL_TX_ARB_TIMEOUT_EN
   localparam int TW = $clog2(TIMEOUT+1);
   logic [TW-1:0]     tmo_q,   tmo_d;
`endif

   logic              pick_found_s;
   logic [IW-1:0]     pick_idx_s;
   logic [IW-1:0]     pick_cand_s;
   logic [IW+2:0]     byte_base_s;
   logic [7:0]        sel_data_s;

   // (base + off) mod N_REQ; both operands are below N_REQ so one subtract suffices
   function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base,
                                              input logic [IW:0]   off);
      logic [IW:0] sum;
      sum = {1'b0, base} + off;
      if (sum >= N_W) begin
         sum = sum - N_W;
      end else begin
         sum = sum;
      end
      return sum[IW-1:0];
   endfunction

   function automatic logic [N_REQ-1:0] to_onehot(input logic [IW-1:0] idx);
      logic [N_REQ-1:0] v;
      v      = {N_REQ{1'b0}};
      v[idx] = 1'b1;
      return v;
   endfunction

   assign byte_base_s = {gidx_q, 3'b000};
   assign sel_data_s  = i_data[byte_base_s +: 8];

   // Round-robin search: first set request at or above rr_q, wrapping around
   always_comb begin
      pick_found_s = 1'b0;
      pick_idx_s   = {IW{1'b0}};
      pick_cand_s  = {IW{1'b0}};
      for (int i = 0; i < N_REQ; i++) begin
         pick_cand_s = wrap_add(rr_q, (IW+1)'(i));
         if (!pick_found_s && i_req[pick_cand_s]) begin
            pick_found_s = 1'b1;
            pick_idx_s   = pick_cand_s;
         end else begin
            pick_found_s = pick_found_s;
         end
      end
   end

   // Next-state and registered-output logic of the packet FSM
   always_comb begin
      state_d = state_q;
      grant_d = grant_q;
      gidx_d  = gidx_q;
      rr_d    = rr_q;
      ack_d   = {N_REQ{1'b0}};
      wr_d    = wr_q;
      data_d  = data_q;
      last_d  = last_q;
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
      tmo_d   = tmo_q;
`endif
      case (state_q)
         ST_IDLE: begin
            wr_d = 1'b0;
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
            tmo_d = {TW{1'b0}};
`endif
            if (pick_found_s) begin
               grant_d = to_onehot(pick_idx_s);
               gidx_d  = pick_idx_s;
               state_d = ST_LOAD;
            end else begin
               grant_d = {N_REQ{1'b0}};
            end
         end
         ST_LOAD: begin
            if (i_req[gidx_q]) begin
               data_d  = sel_data_s;
               last_d  = i_last[gidx_q];
               wr_d    = 1'b1;
               state_d = ST_SEND;
            end else begin
               // Owner paused: it keeps the lock
               wr_d = 1'b0;
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
               if (tmo_q == TW'(TIMEOUT - 1)) begin
                  grant_d = {N_REQ{1'b0}};
                  rr_d    = wrap_add(gidx_q, {{IW{1'b0}}, 1'b1});
                  tmo_d   = {TW{1'b0}};
                  state_d = ST_IDLE;
               end else begin
                  tmo_d = tmo_q + TW'(1);
               end
`endif
            end
         end
         ST_SEND: begin
            if (!i_busy) begin
               wr_d    = 1'b0;
               ack_d   = grant_q;
               state_d = ST_GAP;
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
               tmo_d   = {TW{1'b0}};
`endif
            end else begin
               wr_d = 1'b1;
            end
         end
         ST_GAP: begin
            // Single idle clock so serial_tx has time to raise o_busy
            if (last_q) begin
               grant_d = {N_REQ{1'b0}};
               rr_d    = wrap_add(gidx_q, {{IW{1'b0}}, 1'b1});
               state_d = ST_IDLE;
            end else begin
               state_d = ST_LOAD;
            end
         end
         default: begin
            grant_d = {N_REQ{1'b0}};
            wr_d    = 1'b0;
            state_d = ST_IDLE;
         end
      endcase
   end

   // State and output registers with synchronous active-low reset
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         state_q <= ST_IDLE;
         grant_q <= {N_REQ{1'b0}};
         gidx_q  <= {IW{1'b0}};
         rr_q    <= {IW{1'b0}};
         ack_q   <= {N_REQ{1'b0}};
         wr_q    <= 1'b0;
         data_q  <= 8'h00;
         last_q  <= 1'b0;
      end else begin
         state_q <= state_d;
         grant_q <= grant_d;
         gidx_q  <= gidx_d;
         rr_q    <= rr_d;
         ack_q   <= ack_d;
         wr_q    <= wr_d;
         data_q  <= data_d;
         last_q  <= last_d;
      end
   end

`ifdef SERIAL_TX_ARB_TIMEOUT_EN
   // Stall counter for the lock-release timeout
   always_ff @(posedge i_clk) begin
      if (!i_rst_n) begin
         tmo_q <= {TW{1'b0}};
      end else begin
         tmo_q <= tmo_d;
      end
   end
`endif

   assign o_ack   = ack_q;
   assign o_grant = grant_q;
   assign o_wr    = wr_q;
   assign o_data  = data_q;

endmodule

// File: tb/tb_serial_tx_arbiter.sv
module tb_serial_tx_arbiter;
   localparam int N    = 4;
   localparam int TMO  = 16;
   localparam int MAXB = 16;

   logic           clk;
   logic           rst_n;
   logic [N-1:0]   req;
   logic [8*N-1:0] data;
   logic [N-1:0]   last;
   logic [N-1:0]   ack;
   logic [N-1:0]   grant;
   logic           wr;
   logic [7:0]     odata;
   logic           busy;

   initial clk = 1'b0;
   always #5 clk = ~clk;

   serial_tx_arbiter #(.N_REQ(N), .TIMEOUT(TMO)) dut (
      .i_clk   (clk),
      .i_rst_n (rst_n),
      .i_req   (req),
      .i_data  (data),
      .i_last  (last),
      .o_ack   (ack),
      .o_grant (grant),
      .o_wr    (wr),
      .o_data  (odata),
      .i_busy  (busy)
   );

   int checks = 0;
   int errors = 0;

   // Stimulus: per-requester byte streams
   logic [7:0] bmem [N][MAXB];
   logic       lmem [N][MAXB];
   int         blen [N];
   int         dptr [N];
   int         pcnt [N];

   // Packet-level reference model state
   bit         mon_en = 1'b1;
   int         mptr [N];
   int         owner = -1;
   int         rr = 0;
   logic [N-1:0] exp_ack = '0;
   bit         prev_hold = 1'b0;
   logic [7:0] prev_data = 8'h00;
   logic [7:0] wire_q [$];
   int         ack_q [$];

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (t=%0t)", nm, act, exp, $time);
      end
   endtask

   // Reference model: the wire must carry whole packets, owners chosen
   // round-robin among requesters that still have bytes queued.
   task automatic model_step();
      if (!rst_n) begin
         for (int k = 0; k < N; k++) mptr[k] = 0;
         owner = -1; rr = 0; exp_ack = '0; prev_hold = 1'b0;
         wire_q.delete(); ack_q.delete();
      end else if (mon_en) begin
         chk("ack_pulse", ack, exp_ack);
         chk("grant_onehot0", $onehot0(grant), 1);
         if (prev_hold) begin
            chk("hold_wr", wr, 1);
            chk("hold_data", odata, prev_data);
         end
         exp_ack = '0;
         if (wr && !busy) begin
            if (owner < 0) begin
               for (int i = 0; i < N; i++) begin
                  if (owner < 0 && mptr[(rr + i) % N] < blen[(rr + i) % N]) owner = (rr + i) % N;
               end
            end
            if (owner < 0) begin
               chk("unexpected_write", {24'h0, odata}, 32'hFFFF_FFFF);
            end else begin
               logic [N-1:0] eg;
               eg = '0; eg[owner] = 1'b1;
               chk("grant_owner", grant, eg);
               chk("wire_byte", odata, bmem[owner][mptr[owner]]);
               wire_q.push_back(odata);
               ack_q.push_back(owner);
               exp_ack = eg;
               if (lmem[owner][mptr[owner]]) begin
                  mptr[owner]++;
                  rr = (owner + 1) % N;
                  owner = -1;
               end else begin
                  mptr[owner]++;
               end
            end
         end
         prev_hold = wr && busy;
         prev_data = odata;
      end
   endtask

   task automatic tick();
      @(negedge clk);
      model_step();
      @(posedge clk);
      #2;
   endtask

   task automatic clear_stim();
      for (int k = 0; k < N; k++) blen[k] = 0;
   endtask

   task automatic do_reset();
      rst_n = 1'b0; req = '0; busy = 1'b0; last = '0; data = '0;
      tick(); tick();
   endtask

   // Requesters follow the handshake: raise req, hold until ack, drop for the
   // ack cycle. Non-first bytes of a packet may be delayed a few clocks.
   task automatic run_traffic(input int budget, input bit busy_rand, input bit pause_en);
      int cyc, total_b, total_d;
      bit first, done;
      for (int k = 0; k < N; k++) begin dptr[k] = 0; pcnt[k] = 0; end
      req = '0;
      cyc = 0;
      done = 1'b0;
      while (cyc < budget && !done) begin
         for (int k = 0; k < N; k++) begin
            if (ack[k]) begin
               dptr[k]++; req[k] = 1'b0; pcnt[k] = 0;
            end else if (dptr[k] < blen[k]) begin
               if (!req[k]) begin
                  if (dptr[k] == 0) first = 1'b1;
                  else first = lmem[k][dptr[k]-1];
                  if (first || !pause_en || pcnt[k] >= 4 || $urandom_range(0, 1) == 0) req[k] = 1'b1;
                  else pcnt[k]++;
               end
            end else begin
               req[k] = 1'b0;
            end
            if (req[k]) begin
               data[8*k +: 8] = bmem[k][dptr[k]];
               last[k] = lmem[k][dptr[k]];
            end else begin
               data[8*k +: 8] = 8'($urandom);
               last[k] = 1'($urandom);
            end
         end
         busy = busy_rand ? ($urandom_range(0, 2) == 0) : 1'b0;
         done = 1'b1;
         for (int k = 0; k < N; k++) if (dptr[k] != blen[k]) done = 1'b0;
         if (!done) begin tick(); cyc++; end
      end
      total_b = 0; total_d = 0;
      for (int k = 0; k < N; k++) begin total_b += blen[k]; total_d += dptr[k]; end
      chk("all_bytes_acked", total_d, total_b);
      req = '0; busy = 1'b0;
      tick(); tick(); tick();
      chk("idle_grant", grant, 0);
      chk("idle_wr", wr, 0);
      chk("wire_count", wire_q.size(), total_b);
   endtask

   initial begin
      int n, nb;
      bit ack_seen;
      rst_n = 1'b0; req = '0; data = '0; last = '0; busy = 1'b0;
      clear_stim();

      // Reset with req held, then grant on clock 1 and write on clock 2
      blen[0] = 1; bmem[0][0] = 8'h41; lmem[0][0] = 1'b1;
      req = 4'b0001; data[7:0] = 8'h41; last = 4'b0001;
      tick(); tick();
      chk("rst_grant", grant, 0);
      chk("rst_wr", wr, 0);
      rst_n = 1'b1;
      tick();
      chk("clk1_grant", grant, 4'b0001);
      chk("clk1_wr", wr, 0);
      tick();
      chk("clk2_wr", wr, 1);
      chk("clk2_data", odata, 8'h41);
      tick();
      chk("clk3_ack", ack, 4'b0001);
      req = '0;
      tick(); tick();

      // "HI" from requester 0 while requester 2 waits with "K"
      clear_stim();
      blen[0] = 2; bmem[0][0] = 8'h48; lmem[0][0] = 1'b0; bmem[0][1] = 8'h49; lmem[0][1] = 1'b1;
      blen[2] = 1; bmem[2][0] = 8'h4B; lmem[2][0] = 1'b1;
      do_reset(); rst_n = 1'b1;
      run_traffic(200, 1'b0, 1'b0);
      chk("hik_0", wire_q[0], 8'h48);
      chk("hik_1", wire_q[1], 8'h49);
      chk("hik_2", wire_q[2], 8'h4B);
      chk("hik_ack0", ack_q[0], 0);
      chk("hik_ack1", ack_q[1], 0);
      chk("hik_ack2", ack_q[2], 2);

      // All four requesters, single-byte packets, two rounds
      clear_stim();
      for (int k = 0; k < N; k++) begin
         blen[k] = 2;
         for (int j = 0; j < 2; j++) begin bmem[k][j] = 8'h41 + 8'(k); lmem[k][j] = 1'b1; end
      end
      do_reset(); rst_n = 1'b1;
      run_traffic(300, 1'b0, 1'b0);
      for (int i = 0; i < 8; i++) begin
         chk("rr_byte", wire_q[i], 8'h41 + 8'(i % 4));
         chk("rr_ack", ack_q[i], i % 4);
      end

      // Busy held 50 clocks during SEND
      clear_stim();
      blen[0] = 1; bmem[0][0] = 8'h5A; lmem[0][0] = 1'b1;
      do_reset(); rst_n = 1'b1;
      req = 4'b0001; data[7:0] = 8'h5A; last = 4'b0001; busy = 1'b1;
      tick(); tick();
      chk("busy_wr", wr, 1);
      for (int i = 0; i < 50; i++) begin
         tick();
         chk("busy_hold_wr", wr, 1);
         chk("busy_hold_data", odata, 8'h5A);
         chk("busy_no_ack", ack, 0);
      end
      busy = 1'b0;
      tick();
      chk("busy_release_ack", ack, 4'b0001);
      chk("busy_release_wr", wr, 0);
      req = '0;
      tick(); tick();

      // Reset during SEND abandons the packet
      clear_stim();
      blen[0] = 1; bmem[0][0] = 8'h51; lmem[0][0] = 1'b1;
      do_reset(); rst_n = 1'b1;
      req = 4'b0001; data[7:0] = 8'h51; last = 4'b0001; busy = 1'b1;
      tick(); tick(); tick();
      chk("send_q_wr", wr, 1);
      chk("send_q_data", odata, 8'h51);
      rst_n = 1'b0;
      tick();
      chk("midrst_wr", wr, 0);
      chk("midrst_grant", grant, 0);
      chk("midrst_ack", ack, 0);
      rst_n = 1'b1; req = '0; busy = 1'b0;
      tick();
      chk("midrst_ack2", ack, 0);
      tick();
      chk("midrst_ack3", ack, 0);
      chk("midrst_grant3", grant, 0);

      // Owner 1 stalls after a non-last byte; requester 3 pending
      mon_en = 1'b0;
      clear_stim();
      do_reset(); rst_n = 1'b1;
      req = 4'b1010; data[15:8] = 8'h61; last[1] = 1'b0; data[31:24] = 8'h63; last[3] = 1'b1;
      tick();
      chk("stall_grant", grant, 4'b0010);
      tick();
      chk("stall_wr", wr, 1);
      tick();
      chk("stall_ack", ack, 4'b0010);
      req[1] = 1'b0;
      tick();
      ack_seen = 1'b0;
`ifdef SERIAL_TX_ARB_TIMEOUT_EN
      n = 0;
      while (grant != 4'b1000 && n < 40) begin
         tick(); n++;
         if (ack != 0) ack_seen = 1'b1;
      end
      chk("timeout_release_window", (n >= 16 && n <= 18), 1);
      chk("timeout_no_ack", ack_seen, 0);
`else
      for (int i = 0; i < 40; i++) begin
         tick();
         if (ack != 0) ack_seen = 1'b1;
      end
      chk("nolock_release_grant", grant, 4'b0010);
      chk("nolock_wr", wr, 0);
      chk("nolock_no_ack", ack_seen, 0);
`endif
      req = '0;
      mon_en = 1'b1;

      // Randomized packets, random busy and pauses
      for (int it = 0; it < 20; it++) begin
         clear_stim();
         for (int k = 0; k < N; k++) begin
            nb = 0;
            n = $urandom_range(0, 3);
            for (int p = 0; p < n; p++) begin
               int len;
               len = $urandom_range(1, 4);
               for (int j = 0; j < len; j++) begin
                  bmem[k][nb] = 8'($urandom);
                  lmem[k][nb] = (j == len - 1);
                  nb++;
               end
            end
            blen[k] = nb;
         end
         do_reset(); rst_n = 1'b1;
         run_traffic(3000, 1'b1, 1'b1);
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule
